// File: rtl/z80_dma_arbiter.sv
// z80_dma_arbiter: arbitrates two bus masters for the Z80 bus through the BUSRQ/BUSAK handshake.
module z80_dma_arbiter #(
    parameter int MAX_HOLD = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cen,
    input  logic [1:0] req,
    input  logic       busak_n,
    output logic       busrq_n,
    output logic [1:0] gnt,
    output logic       sel,
    output logic       bus_owned
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] GRANT   = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;
    logic [1:0] state;
    logic [7:0] cnt;
    logic       last_owner;
    logic       win;
    logic       hold_done;
    // On a tie, the requester that did not own the bus last time wins
    assign win       = (req == 2'b11) ? ~last_owner : req[1];
    assign hold_done = (MAX_HOLD != 0) && (cnt == 8'(MAX_HOLD - 1));
    assign bus_owned = |gnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            busrq_n    <= 1'b1;
            gnt        <= 2'b00;
            sel        <= 1'b0;
            cnt        <= 8'd0;
            last_owner <= 1'b0;
        end else if (cen) begin
            case (state)
                IDLE: if (req != 2'b00) begin
                    state   <= REQ;
                    sel     <= win;
                    busrq_n <= 1'b0;
                end
                REQ: if (!busak_n) begin
                    // An owner that gave up mid-handshake still lets the CPU finish acknowledging
                    if (req[sel]) begin
                        state <= GRANT;
                        gnt   <= sel ? 2'b10 : 2'b01;
                        cnt   <= 8'd0;
                    end else begin
                        state   <= RELEASE;
                        busrq_n <= 1'b1;
                    end
                end
                GRANT: begin
                    cnt <= (cnt == 8'hff) ? cnt : cnt + 8'd1;
                    if (busak_n || !req[sel] || hold_done) begin
                        state   <= RELEASE;
                        gnt     <= 2'b00;
                        busrq_n <= 1'b1;
                    end
                end
                default: if (busak_n) begin
                    state      <= IDLE;
                    last_owner <= sel;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_z80_dma_arbiter.sv
// tb_z80_dma_arbiter: directed scenario bench for z80_dma_arbiter with MAX_HOLD=4.
module tb_z80_dma_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cen = 1'b1;
    logic [1:0] req = 2'b00;
    logic       busak_n = 1'b1;
    logic       busrq_n;
    logic [1:0] gnt;
    logic       sel;
    logic       bus_owned;
    int errors = 0;
    int checks = 0;

    z80_dma_arbiter #(.MAX_HOLD(4)) dut (
        .clk(clk), .reset(reset), .cen(cen), .req(req), .busak_n(busak_n),
        .busrq_n(busrq_n), .gnt(gnt), .sel(sel), .bus_owned(bus_owned)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; cen = 1'b1; req = 2'b00; busak_n = 1'b1;
        tick(); tick();
        checks++; if (busrq_n !== 1'b1) begin errors++; $display("FAIL reset_busrq_n got=%b exp=1", busrq_n); end
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
        checks++; if (sel !== 1'b0) begin errors++; $display("FAIL reset_sel got=%b exp=0", sel); end
        checks++; if (bus_owned !== 1'b0) begin errors++; $display("FAIL reset_bus_owned got=%b exp=0", bus_owned); end
        reset = 1'b0;
        tick();
        checks++; if (busrq_n !== 1'b1) begin errors++; $display("FAIL idle_busrq_n got=%b exp=1", busrq_n); end
    endtask

    task automatic test_single();
        req = 2'b01;
        tick();
        checks++; if (busrq_n !== 1'b0) begin errors++; $display("FAIL single_busrq_latency got=%b exp=0", busrq_n); end
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL single_gnt_before_ack got=%b exp=00", gnt); end
        tick(); tick();
        busak_n = 1'b0;
        tick();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL single_gnt got=%b exp=01", gnt); end
        checks++; if (sel !== 1'b0) begin errors++; $display("FAIL single_sel got=%b exp=0", sel); end
        checks++; if (bus_owned !== 1'b1) begin errors++; $display("FAIL single_bus_owned got=%b exp=1", bus_owned); end
        req = 2'b00;
        tick();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL single_release_gnt got=%b exp=00", gnt); end
        checks++; if (busrq_n !== 1'b1) begin errors++; $display("FAIL single_release_busrq_n got=%b exp=1", busrq_n); end
        busak_n = 1'b1;
        tick(); tick();
    endtask

    task automatic test_round_robin();
        reset = 1'b1; tick(); reset = 1'b0;
        req = 2'b11;
        tick();
        checks++; if (busrq_n !== 1'b0) begin errors++; $display("FAIL rr_busrq_n got=%b exp=0", busrq_n); end
        busak_n = 1'b0;
        tick();
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL rr_first_gnt got=%b exp=10", gnt); end
        checks++; if (sel !== 1'b1) begin errors++; $display("FAIL rr_first_sel got=%b exp=1", sel); end
        req = 2'b01;
        tick();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rr_release_gnt got=%b exp=00", gnt); end
        busak_n = 1'b1;
        tick();
        checks++; if (busrq_n !== 1'b1) begin errors++; $display("FAIL rr_idle_gap got=%b exp=1", busrq_n); end
        tick();
        checks++; if (busrq_n !== 1'b0) begin errors++; $display("FAIL rr_rerequest got=%b exp=0", busrq_n); end
        busak_n = 1'b0;
        tick();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rr_second_gnt got=%b exp=01", gnt); end
        checks++; if (sel !== 1'b0) begin errors++; $display("FAIL rr_second_sel got=%b exp=0", sel); end
        req = 2'b00;
        tick();
        busak_n = 1'b1;
        tick(); tick();
    endtask

    task automatic test_max_hold();
        req = 2'b01;
        tick();
        busak_n = 1'b0;
        tick();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL hold_cycle0 got=%b exp=01", gnt); end
        for (int i = 1; i < 4; i++) begin
            tick();
            checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL hold_cycle%0d got=%b exp=01", i, gnt); end
        end
        tick();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL hold_expire_gnt got=%b exp=00", gnt); end
        checks++; if (busrq_n !== 1'b1) begin errors++; $display("FAIL hold_expire_busrq_n got=%b exp=1", busrq_n); end
        tick();
        checks++; if (busrq_n !== 1'b1) begin errors++; $display("FAIL hold_wait_ack got=%b exp=1", busrq_n); end
        busak_n = 1'b1;
        tick();
        checks++; if (busrq_n !== 1'b1) begin errors++; $display("FAIL hold_idle_gap got=%b exp=1", busrq_n); end
        tick();
        checks++; if (busrq_n !== 1'b0) begin errors++; $display("FAIL hold_regrant_req got=%b exp=0", busrq_n); end
        req = 2'b00; busak_n = 1'b0;
        tick();
        busak_n = 1'b1;
        tick(); tick();
    endtask

    task automatic test_cen_gating();
        req = 2'b01;
        tick();
        busak_n = 1'b0;
        tick();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL cen_grant got=%b exp=01", gnt); end
        for (int i = 0; i < 8; i++) begin
            cen = (i % 2 == 1);
            tick();
            if (i < 7) begin
                checks++; if (gnt !== 2'b01 || busrq_n !== 1'b0) begin errors++; $display("FAIL cen_hold%0d got gnt=%b busrq_n=%b exp 01/0", i, gnt, busrq_n); end
            end else begin
                checks++; if (gnt !== 2'b00 || busrq_n !== 1'b1) begin errors++; $display("FAIL cen_expire got gnt=%b busrq_n=%b exp 00/1", gnt, busrq_n); end
            end
        end
        cen = 1'b1; req = 2'b00; busak_n = 1'b1;
        tick(); tick();
    endtask

    task automatic test_req_drop();
        req = 2'b01;
        tick();
        req = 2'b00;
        tick();
        checks++; if (busrq_n !== 1'b0 || gnt !== 2'b00) begin errors++; $display("FAIL drop_hold_req got busrq_n=%b gnt=%b exp 0/00", busrq_n, gnt); end
        busak_n = 1'b0;
        tick();
        checks++; if (busrq_n !== 1'b1 || gnt !== 2'b00) begin errors++; $display("FAIL drop_release got busrq_n=%b gnt=%b exp 1/00", busrq_n, gnt); end
        busak_n = 1'b1;
        tick();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL drop_idle_gnt got=%b exp=00", gnt); end
    endtask

    task automatic test_illegal_busak();
        req = 2'b01;
        tick();
        busak_n = 1'b0;
        tick();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL illegal_grant got=%b exp=01", gnt); end
        busak_n = 1'b1;
        tick();
        checks++; if (gnt !== 2'b00 || busrq_n !== 1'b1) begin errors++; $display("FAIL illegal_release got gnt=%b busrq_n=%b exp 00/1", gnt, busrq_n); end
        req = 2'b00;
        tick(); tick();
    endtask

    task automatic test_reset_mid_grant();
        req = 2'b10;
        tick();
        busak_n = 1'b0;
        tick();
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL rst_grant got=%b exp=10", gnt); end
        #2 reset = 1'b1;
        #1;
        checks++; if (gnt !== 2'b00 || busrq_n !== 1'b1 || bus_owned !== 1'b0) begin errors++; $display("FAIL rst_async got gnt=%b busrq_n=%b owned=%b exp 00/1/0", gnt, busrq_n, bus_owned); end
        busak_n = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checks++; if (busrq_n !== 1'b0 || gnt !== 2'b00) begin errors++; $display("FAIL rst_restart got busrq_n=%b gnt=%b exp 0/00", busrq_n, gnt); end
        tick();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rst_wait_ack got=%b exp=00", gnt); end
        busak_n = 1'b0;
        tick();
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL rst_regrant got=%b exp=10", gnt); end
        req = 2'b00;
        tick();
        busak_n = 1'b1;
        tick();
    endtask

    // gnt must stay one-hot and only while the CPU is being asked for the bus
    always @(negedge clk) begin
        if (!reset && (gnt == 2'b11 || (gnt != 2'b00 && busrq_n))) begin
            errors++;
            checks++;
            $display("FAIL gnt_invariant got gnt=%b busrq_n=%b", gnt, busrq_n);
        end
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_max_hold();
        test_cen_gating();
        test_req_drop();
        test_illegal_busak();
        test_reset_mid_grant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
